// File: rtl/scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard: sizes, drain FSM states
// and the packed operand-index types.
package scoreboard_pkg;

    localparam int unsigned NREGS_DEFAULT        = 32;
    localparam int unsigned MAX_INFLIGHT_DEFAULT = 4;
    localparam int unsigned REG_IDX_W            = 5;
    localparam int unsigned N_SRC                = 3;
    localparam int unsigned N_DST                = 2;
    localparam int unsigned INFLIGHT_W           = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef reg_idx_t [N_SRC-1:0] src_regs_t;
    typedef reg_idx_t [N_DST-1:0] dst_regs_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/retire/control bundle between decode and the register scoreboard.
interface reg_scoreboard_if
    import scoreboard_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT
);

    logic                  dc_valid;
    logic                  dc_ready;
    logic [N_SRC-1:0]      src_valid;
    src_regs_t             src_reg;
    logic [N_DST-1:0]      dst_valid;
    dst_regs_t             dst_reg;
    logic                  wb_uop;
    logic [N_DST-1:0]      wb_dst_valid;
    dst_regs_t             wb_dst_reg;
    logic                  flush;
    logic                  drain_req;
    logic                  drain_done;
    logic [NREGS-1:0]      busy;
    logic [INFLIGHT_W-1:0] inflight;

    modport master (
        output dc_valid, src_valid, src_reg, dst_valid, dst_reg,
        output wb_uop, wb_dst_valid, wb_dst_reg, flush, drain_req,
        input  dc_ready, drain_done, busy, inflight
    );

    modport slave (
        input  dc_valid, src_valid, src_reg, dst_valid, dst_reg,
        input  wb_uop, wb_dst_valid, wb_dst_reg, flush, drain_req,
        output dc_ready, drain_done, busy, inflight
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: RAW/WAW issue gating, in-flight uop counter and drain FSM.
// Define WB_BYPASS_EN to let registers released by this cycle's writeback issue immediately.
module reg_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NREGS        = NREGS_DEFAULT,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    reg_scoreboard_if.slave sb
);

    sb_state_e             state_q, state_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic                  drain_done_q, drain_done_d;

    logic [NREGS-1:0]      set_mask;
    logic [NREGS-1:0]      clr_mask;
    logic [NREGS-1:0]      busy_chk;
    logic                  hazard;
    logic                  dc_ready_c;
    logic                  accept;

    // Per-register decode of issuing destinations and retiring destinations
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int r = 0; r < int'(NREGS); r++) begin
            for (int d = 0; d < int'(N_DST); d++) begin
                if (sb.dst_valid[d] && (sb.dst_reg[d] == REG_IDX_W'(r)))
                    set_mask[r] = 1'b1;
                if (sb.wb_uop && sb.wb_dst_valid[d] && (sb.wb_dst_reg[d] == REG_IDX_W'(r)))
                    clr_mask[r] = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign busy_chk = busy_q & ~clr_mask;
`else
    assign busy_chk = busy_q;
`endif

    // RAW on any valid source, WAW on any valid destination
    always_comb begin
        hazard = 1'b0;
        for (int r = 0; r < int'(NREGS); r++) begin
            for (int s = 0; s < int'(N_SRC); s++) begin
                if (sb.src_valid[s] && (sb.src_reg[s] == REG_IDX_W'(r)) && busy_chk[r])
                    hazard = 1'b1;
            end
            if (set_mask[r] && busy_chk[r])
                hazard = 1'b1;
        end
    end

    assign dc_ready_c = !reset && (state_q == RUN) && !sb.drain_req && !sb.flush &&
                        (32'(inflight_q) < MAX_INFLIGHT) && !hazard;
    assign accept     = sb.dc_valid && dc_ready_c;

    always_comb begin
        busy_d     = busy_q;
        inflight_d = inflight_q;
        state_d    = state_q;
        if (sb.flush) begin
            busy_d     = '0;
            inflight_d = '0;
            state_d    = RUN;
        end else begin
            // set wins over a same-cycle clear of the same register
            busy_d = (busy_q & ~clr_mask) | ({NREGS{accept}} & set_mask);
            if (accept && !sb.wb_uop)
                inflight_d = inflight_q + INFLIGHT_W'(1);
            else if (!accept && sb.wb_uop && (inflight_q != '0))
                inflight_d = inflight_q - INFLIGHT_W'(1);
            case (state_q)
                RUN:     if (sb.drain_req) state_d = DRAIN;
                DRAIN:   if (inflight_d == '0) state_d = DONE;
                DONE:    state_d = RUN;
                default: state_d = RUN;
            endcase
        end
        drain_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            busy_q       <= '0;
            inflight_q   <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            inflight_q   <= inflight_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign sb.dc_ready   = dc_ready_c;
    assign sb.busy       = busy_q;
    assign sb.inflight   = inflight_q;
    assign sb.drain_done = drain_done_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a reference model feeding an expectation queue.
module tb_reg_scoreboard;
    import scoreboard_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] busy;
        logic [2:0]  inflight;
        logic        drain_done;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [31:0] m_busy;
    int          m_inf;
    int          m_st;
    exp_t        exp_q[$];

    reg_scoreboard_if #(.NREGS(32)) sb_if ();

    reg_scoreboard #(.NREGS(32), .MAX_INFLIGHT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .sb   (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset                 = 1'b0;
        sb_if.dc_valid        = 1'b0;
        sb_if.src_valid       = '0;
        sb_if.src_reg         = '0;
        sb_if.dst_valid       = '0;
        sb_if.dst_reg         = '0;
        sb_if.wb_uop          = 1'b0;
        sb_if.wb_dst_valid    = '0;
        sb_if.wb_dst_reg      = '0;
        sb_if.flush           = 1'b0;
        sb_if.drain_req       = 1'b0;
    endtask

    task automatic ready_is(input string tag, input logic exp);
        #1;
        check(tag, 32'(sb_if.dc_ready), 32'(exp));
    endtask

    // Check dc_ready against the model, advance model and DUT one edge, compare state
    task automatic cycle(input string tag);
        exp_t        e;
        logic [31:0] clr;
        logic [31:0] set;
        logic [31:0] chk_b;
        logic        rdy;
        logic        acc;
        #1;
        clr = '0;
        set = '0;
        for (int d = 0; d < 2; d++) begin
            if (sb_if.wb_uop && sb_if.wb_dst_valid[d]) clr[sb_if.wb_dst_reg[d]] = 1'b1;
            if (sb_if.dst_valid[d]) set[sb_if.dst_reg[d]] = 1'b1;
        end
        chk_b = m_busy;
`ifdef WB_BYPASS_EN
        chk_b = m_busy & ~clr;
`endif
        rdy = !reset && (m_st == 0) && !sb_if.drain_req && !sb_if.flush &&
              (m_inf < 4) && ((set & chk_b) == 32'h0);
        for (int s = 0; s < 3; s++)
            if (sb_if.src_valid[s] && chk_b[sb_if.src_reg[s]]) rdy = 1'b0;
        check({tag, ".ready"}, 32'(sb_if.dc_ready), 32'(rdy));
        acc = sb_if.dc_valid && rdy;
        if (reset || sb_if.flush) begin
            m_busy = '0;
            m_inf  = 0;
            m_st   = 0;
        end else begin
            m_busy = (m_busy & ~clr) | (acc ? set : 32'h0);
            if (acc && !sb_if.wb_uop) m_inf++;
            else if (!acc && sb_if.wb_uop && m_inf > 0) m_inf--;
            case (m_st)
                0:       if (sb_if.drain_req) m_st = 1;
                1:       if (m_inf == 0) m_st = 2;
                default: m_st = 0;
            endcase
        end
        e.tag        = tag;
        e.busy       = m_busy;
        e.inflight   = 3'(m_inf);
        e.drain_done = (m_st == 2);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check({e.tag, ".busy"},       sb_if.busy,                e.busy);
        check({e.tag, ".inflight"},   32'(sb_if.inflight),       32'(e.inflight));
        check({e.tag, ".drain_done"}, 32'(sb_if.drain_done),     32'(e.drain_done));
    endtask

    task automatic do_reset();
        idle();
        reset          = 1'b1;
        sb_if.dc_valid = 1'b1;
        sb_if.dst_valid = 2'b01;
        cycle("rst");
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_busy   = '0;
        m_inf    = 0;
        m_st     = 0;

        do_reset();
        check("rst.busy_const", sb_if.busy, 32'h0);

        // RAW stall on RAX
        idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b01; sb_if.dst_reg = {5'd0, 5'd0};
        cycle("raw.issue");
        check("raw.busy_set", sb_if.busy, 32'h1);
        for (int i = 0; i < 2; i++) begin
            idle(); sb_if.dc_valid = 1'b1; sb_if.src_valid = 3'b001; sb_if.src_reg = '0;
            ready_is("raw.stall", 1'b0);
            cycle("raw.stall_cyc");
        end
        idle(); sb_if.dc_valid = 1'b1; sb_if.src_valid = 3'b001; sb_if.src_reg = '0;
        sb_if.wb_uop = 1'b1; sb_if.wb_dst_valid = 2'b01; sb_if.wb_dst_reg = {5'd0, 5'd0};
`ifdef WB_BYPASS_EN
        ready_is("raw.wb_cycle", 1'b1);
`else
        ready_is("raw.wb_cycle", 1'b0);
`endif
        cycle("raw.wb");
        idle(); sb_if.dc_valid = 1'b1; sb_if.src_valid = 3'b001; sb_if.src_reg = '0;
        ready_is("raw.after_wb", 1'b1);
        cycle("raw.reissue");

        // Inflight limit
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); sb_if.dc_valid = 1'b1;
            cycle("lim.acc");
        end
        idle(); sb_if.dc_valid = 1'b1;
        ready_is("lim.full", 1'b0);
        cycle("lim.fifth");
        check("lim.inflight4", 32'(sb_if.inflight), 32'd4);
        idle(); sb_if.wb_uop = 1'b1;
        cycle("lim.retire");
        check("lim.inflight3", 32'(sb_if.inflight), 32'd3);
        idle(); sb_if.dc_valid = 1'b1;
        ready_is("lim.room", 1'b1);
        cycle("lim.refill");

        // Multi-target and duplicate destination
        do_reset();
        idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b11; sb_if.dst_reg = {5'd2, 5'd0};
        cycle("mt.issue");
        check("mt.busy5", sb_if.busy, 32'h5);
        idle(); sb_if.wb_uop = 1'b1; sb_if.wb_dst_valid = 2'b11; sb_if.wb_dst_reg = {5'd2, 5'd0};
        cycle("mt.wb");
        check("mt.busy0", sb_if.busy, 32'h0);
        idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b11; sb_if.dst_reg = {5'd3, 5'd3};
        cycle("mt.dup");
        check("mt.dup_busy", sb_if.busy, 32'h8);

        // Drain sequence
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle(); sb_if.dc_valid = 1'b1;
            cycle("dr.acc");
        end
        idle(); sb_if.dc_valid = 1'b1; sb_if.drain_req = 1'b1;
        ready_is("dr.req_blocks", 1'b0);
        cycle("dr.req");
        idle(); sb_if.dc_valid = 1'b1;
        ready_is("dr.draining", 1'b0);
        cycle("dr.wait");
        idle(); sb_if.wb_uop = 1'b1;
        cycle("dr.wb1");
        idle(); sb_if.wb_uop = 1'b1;
        cycle("dr.wb2");
        check("dr.done_pulse", 32'(sb_if.drain_done), 32'd1);
        idle(); sb_if.dc_valid = 1'b1;
        cycle("dr.done_state");
        check("dr.done_once", 32'(sb_if.drain_done), 32'd0);
        idle(); sb_if.dc_valid = 1'b1;
        ready_is("dr.back_run", 1'b1);
        cycle("dr.run");

        // Flush with simultaneous accept, writeback and drain request
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b11;
            sb_if.dst_reg = {5'(2 * i + 1), 5'(2 * i)};
            cycle("fl.acc");
        end
        idle(); sb_if.wb_uop = 1'b1;
        cycle("fl.retire");
        check("fl.pre_busy", sb_if.busy, 32'h0000_00FF);
        check("fl.pre_inflight", 32'(sb_if.inflight), 32'd3);
        idle(); sb_if.flush = 1'b1; sb_if.drain_req = 1'b1;
        sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b11; sb_if.dst_reg = {5'd9, 5'd8};
        sb_if.wb_uop = 1'b1; sb_if.wb_dst_valid = 2'b01; sb_if.wb_dst_reg = {5'd0, 5'd0};
        ready_is("fl.blocks", 1'b0);
        cycle("fl.flush");
        check("fl.busy0", sb_if.busy, 32'h0);
        check("fl.inflight0", 32'(sb_if.inflight), 32'd0);
        idle(); sb_if.dc_valid = 1'b1;
        ready_is("fl.run", 1'b1);
        cycle("fl.after");

        // Simultaneous accept/retire and underflow guard
        do_reset();
        idle(); sb_if.dc_valid = 1'b1;
        cycle("sim.acc");
        idle(); sb_if.dc_valid = 1'b1; sb_if.wb_uop = 1'b1;
        cycle("sim.both");
        check("sim.unchanged", 32'(sb_if.inflight), 32'd1);
        idle(); sb_if.wb_uop = 1'b1;
        cycle("sim.wb");
        idle(); sb_if.wb_uop = 1'b1;
        cycle("sim.underflow");
        check("sim.stays0", 32'(sb_if.inflight), 32'd0);

        // Same-register set and clear in one cycle
        do_reset();
        idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b01; sb_if.dst_reg = {5'd0, 5'd4};
        cycle("sw.issue");
        idle(); sb_if.dc_valid = 1'b1; sb_if.dst_valid = 2'b01; sb_if.dst_reg = {5'd0, 5'd4};
        sb_if.wb_uop = 1'b1; sb_if.wb_dst_valid = 2'b01; sb_if.wb_dst_reg = {5'd0, 5'd4};
        cycle("sw.set_clr");
`ifdef WB_BYPASS_EN
        check("sw.set_wins", sb_if.busy, 32'h10);
`else
        check("sw.cleared", sb_if.busy, 32'h0);
`endif

        // Reset in the middle of a drain
        do_reset();
        idle(); sb_if.dc_valid = 1'b1;
        cycle("rd.acc");
        idle(); sb_if.drain_req = 1'b1;
        cycle("rd.req");
        idle(); reset = 1'b1; sb_if.wb_uop = 1'b1;
        cycle("rd.reset");
        check("rd.no_pulse", 32'(sb_if.drain_done), 32'd0);
        idle();
        cycle("rd.after");
        check("rd.no_late_pulse", 32'(sb_if.drain_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
